bank_pwm: RTL and testbench

BANK_PWM -- requirements
Module: bank_pwm

---
 rtl/cmd_icd_pkg.sv | 52 +++++
 rtl/bank_pwm_gen.sv | 74 +++++++
 rtl/bank_pwm.sv | 93 +++++++++
 tb/tb_bank_pwm.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_icd_pkg.sv
// ---------------------------------------------------------------------------
// cmd_icd_pkg
// Shared interface definitions for the bank_cmd stream: opcode value,
// command-word field positions and the word builder used by producers.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cmd_icd_pkg;

    localparam int NUM_BANKS = 4;
    localparam int DUTY_W    = 8;

    // Command word layout
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 24;
    localparam int MASK_MSB = 11;
    localparam int MASK_LSB = 8;
    localparam int VAL_MSB  = 7;
    localparam int VAL_LSB  = 0;

    // Opcode that targets the bank duty shadows
    localparam logic [7:0] BANK_OPCODE = 8'hB1;

    // Last pwm_cnt value of a period (period is 255 ticks: 0..254)
    localparam logic [DUTY_W-1:0] PWM_LAST = 8'd254;

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_DECODE = 1'b1
    } cmd_state_e;

    typedef struct packed {
        logic [7:0]           opcode;
        logic [NUM_BANKS-1:0] mask;
        logic [DUTY_W-1:0]    value;
    } bank_cmd_t;

    // Producer-side helper: build a bank write command word
    function automatic logic [31:0] task2bank_cmd(input logic [NUM_BANKS-1:0] mask,
                                                  input logic [DUTY_W-1:0]    value);
        logic [31:0] w;
        w = '0;
        w[OPC_MSB:OPC_LSB]   = BANK_OPCODE;
        w[MASK_MSB:MASK_LSB] = mask;
        w[VAL_MSB:VAL_LSB]   = value;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bank_pwm_gen.sv
// ---------------------------------------------------------------------------
// bank_pwm_gen
// Prescaled 255-tick PWM counter with per-lane duty compare. Active duty
// registers reload from the shadow inputs only at the end of a period.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bank_pwm_gen
    import cmd_icd_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int LANES    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [LANES-1:0][DUTY_W-1:0]  shadow_i,
    output logic [LANES-1:0]              pwm_o,
    output logic [LANES-1:0][DUTY_W-1:0]  active_o
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [15:0]                   presc_q;
    logic [15:0]                   presc_d;
    logic                          tick;
    logic [DUTY_W-1:0]             cnt_q;
    logic [DUTY_W-1:0]             cnt_d;
    logic [LANES-1:0][DUTY_W-1:0]  active_q;
    logic [LANES-1:0]              pwm_q;

    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? 16'd0 : presc_q + 16'd1;
    assign cnt_d   = (cnt_q == PWM_LAST) ? '0 : cnt_q + 8'd1;

    // Prescaler: free-running 0..PRESCALE-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // PWM counter; active duties reload from shadow on the last tick of a period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= '0;
        end else if (tick) begin
            cnt_q <= cnt_d;
            if (cnt_q == PWM_LAST) begin
                active_q <= shadow_i;
            end
        end
    end

    // Registered compare: output follows the counter by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                pwm_q[i] <= (cnt_q < active_q[i]);
            end
        end
    end

    assign pwm_o    = pwm_q;
    assign active_o = active_q;

endmodule

`default_nettype wire

// File: rtl/bank_pwm.sv
// ---------------------------------------------------------------------------
// bank_pwm
// Four-bank PWM controller. A two-state command FSM accepts bank_cmd words,
// writes per-bank duty shadows and counts rejected opcodes; bank_pwm_gen
// produces the outputs from period-synchronous active duties.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bank_pwm
    import cmd_icd_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              asi_cmd_valid,
    output logic                              asi_cmd_ready,
    input  logic [31:0]                       asi_cmd_data,
    output logic [NUM_BANKS-1:0]              bank_out,
    output logic [NUM_BANKS-1:0][DUTY_W-1:0]  duty,
    output logic [15:0]                       bad_cmd_cnt
);

    cmd_state_e                         state_q;
    logic                               ready_q;
    bank_cmd_t                          cmd_q;
    logic [NUM_BANKS-1:0][DUTY_W-1:0]   shadow_q;
    logic [15:0]                        bad_cmd_cnt_q;
    bank_cmd_t                          cmd_d;
    logic                               unused_cmd_bits;

    assign cmd_d.opcode = asi_cmd_data[OPC_MSB:OPC_LSB];
    assign cmd_d.mask   = asi_cmd_data[MASK_MSB:MASK_LSB];
    assign cmd_d.value  = asi_cmd_data[VAL_MSB:VAL_LSB];

    // Reserved bits of the command word are ignored
    assign unused_cmd_bits = ^asi_cmd_data[OPC_LSB-1:MASK_MSB+1];

    // Command FSM: capture in ACCEPT, apply in DECODE; ready is low in DECODE
    // and also for the first cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ACCEPT;
            ready_q       <= 1'b0;
            cmd_q         <= '0;
            shadow_q      <= '0;
            bad_cmd_cnt_q <= '0;
        end else begin
            unique case (state_q)
                ST_ACCEPT: begin
                    if (asi_cmd_valid && ready_q) begin
                        cmd_q   <= cmd_d;
                        state_q <= ST_DECODE;
                        ready_q <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (cmd_q.opcode == BANK_OPCODE) begin
                        for (int i = 0; i < NUM_BANKS; i++) begin
                            if (cmd_q.mask[i]) begin
                                shadow_q[i] <= cmd_q.value;
                            end
                        end
                    end else if (bad_cmd_cnt_q != 16'hFFFF) begin
                        bad_cmd_cnt_q <= bad_cmd_cnt_q + 16'd1;
                    end
                    state_q <= ST_ACCEPT;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    bank_pwm_gen #(
        .PRESCALE (PRESCALE),
        .LANES    (NUM_BANKS)
    ) u_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .shadow_i (shadow_q),
        .pwm_o    (bank_out),
        .active_o (duty)
    );

    assign asi_cmd_ready = ready_q;
    assign bad_cmd_cnt   = bad_cmd_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_bank_pwm.sv
// ---------------------------------------------------------------------------
// tb_bank_pwm
// Self-checking bench for bank_pwm (PRESCALE=1). Rejected-command counts are
// queued when a word is driven and checked when its DECODE cycle completes;
// PWM waveforms are checked against a cycle-count model of the 255-tick period.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bank_pwm;
    import cmd_icd_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid = 1'b0;
    logic [31:0]       data = '0;
    logic              ready;
    logic [3:0]        bank_out;
    logic [3:0][7:0]   duty;
    logic [15:0]       bad;

    int                n_vec = 0;
    int                n_bad = 0;
    int                cyc = 0;

    logic [15:0]       exp_bad_q[$];
    logic [15:0]       exp_bad = '0;
    logic [3:0][7:0]   exp_shadow = '0;
    logic [3:0][7:0]   exp_active = '0;
    logic [3:0][7:0]   act_used = '0;
    int                per_errs;
    int                per_high[4];

    localparam logic [7:0] BAD_OPC = 8'hEE;

    bank_pwm #(.PRESCALE(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .asi_cmd_valid (valid),
        .asi_cmd_ready (ready),
        .asi_cmd_data  (data),
        .bank_out      (bank_out),
        .duty          (duty),
        .bad_cmd_cnt   (bad)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [7:0] opc, input logic [3:0] m, input logic [7:0] v);
        return {opc, 12'h000, m, v};
    endfunction

    // One clock; period end (every 255th edge after release) loads active from shadow
    task automatic step();
        act_used = exp_active;
        @(posedge clk);
        cyc++;
        if (cyc % 255 == 0) exp_active = exp_shadow;
        #1;
    endtask

    task automatic to_boundary();
        for (int k = 0; k < 256; k++) begin
            if (cyc % 255 == 0 && k > 0) break;
            step();
        end
    endtask

    // Expected reject count is computed and queued when the word is driven
    task automatic push_exp(input logic [31:0] w);
        if (w[31:24] != BANK_OPCODE && exp_bad != 16'hFFFF) exp_bad = exp_bad + 16'd1;
        exp_bad_q.push_back(exp_bad);
    endtask

    // Shadow update is applied after the DECODE edge, behind any period-end load
    task automatic apply_shadow(input logic [31:0] w);
        if (w[31:24] == BANK_OPCODE) begin
            for (int i = 0; i < 4; i++) begin
                if (w[8+i]) exp_shadow[i] = w[7:0];
            end
        end
    endtask

    task automatic send_cmd(input string name, input logic [31:0] w);
        logic [15:0] e;
        n_vec++;
        if (ready !== 1'b1) begin n_bad++; $display("FAIL %s ready-idle: got %b expected 1", name, ready); end
        valid = 1'b1;
        data  = w;
        push_exp(w);
        step();
        valid = 1'b0;
        data  = '0;
        n_vec++;
        if (ready !== 1'b0) begin n_bad++; $display("FAIL %s ready-decode: got %b expected 0", name, ready); end
        step();
        apply_shadow(w);
        if (exp_bad_q.size() == 0) begin
            n_vec++; n_bad++; $display("FAIL %s scoreboard: queue empty", name);
        end else begin
            e = exp_bad_q.pop_front();
            n_vec++;
            if (bad !== e) begin n_bad++; $display("FAIL %s bad_cmd_cnt: got %h expected %h", name, bad, e); end
        end
    endtask

    // Run one full period from a boundary, tallying waveform errors and high ticks
    task automatic run_period();
        logic [3:0] expb;
        int ph;
        per_errs = 0;
        for (int i = 0; i < 4; i++) per_high[i] = 0;
        for (int k = 0; k < 255; k++) begin
            step();
            ph = (cyc - 1) % 255;
            for (int i = 0; i < 4; i++) begin
                expb[i] = (ph < int'(act_used[i]));
                if (bank_out[i] === 1'b1) per_high[i]++;
            end
            if (bank_out !== expb) per_errs++;
        end
    endtask

    task automatic do_release();
        rst_n = 1'b1;
        cyc = 0;
        exp_bad = '0; exp_shadow = '0; exp_active = '0; act_used = '0;
        exp_bad_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_vec++;
        if ({ready, bank_out, duty, bad} !== '0) begin
            n_bad++; $display("FAIL reset-state: got rdy=%b out=%b duty=%h bad=%h expected all 0", ready, bank_out, duty, bad);
        end
        do_release();
        n_vec++;
        if (ready !== 1'b0) begin n_bad++; $display("FAIL reset-release-ready: got %b expected 0", ready); end
        step();
        n_vec++;
        if (ready !== 1'b1) begin n_bad++; $display("FAIL reset-first-edge-ready: got %b expected 1", ready); end
    endtask

    task automatic test_bad_opcode();
        for (int k = 0; k < 3; k++) send_cmd("bad_opcode", mk(BAD_OPC, 4'hF, 8'd99));
        n_vec++;
        if (bad !== 16'd3) begin n_bad++; $display("FAIL bad_opcode-count3: got %0d expected 3", bad); end
        send_cmd("mask0_noop", mk(BANK_OPCODE, 4'h0, 8'd77));
        n_vec++;
        if (duty !== 32'h0) begin n_bad++; $display("FAIL bad_opcode-duty: got %h expected 0", duty); end
    endtask

    task automatic test_duty64();
        send_cmd("duty64", mk(BANK_OPCODE, 4'b0001, 8'd64));
        n_vec++;
        if (duty !== 32'h0) begin n_bad++; $display("FAIL duty64-before-period: got %h expected 0", duty); end
        to_boundary();
        n_vec++;
        if (duty !== {8'd0, 8'd0, 8'd0, 8'd64}) begin n_bad++; $display("FAIL duty64-readback: got %h expected 00000040", duty); end
        run_period();
        n_vec++;
        if (per_errs != 0) begin n_bad++; $display("FAIL duty64-pattern: got %0d bad cycles expected 0", per_errs); end
        n_vec++;
        if (per_high[0] != 64) begin n_bad++; $display("FAIL duty64-high-ticks: got %0d expected 64", per_high[0]); end
    endtask

    task automatic test_all_banks();
        send_cmd("all_255", mk(BANK_OPCODE, 4'b1111, 8'd255));
        send_cmd("bank1_0", mk(BANK_OPCODE, 4'b0010, 8'd0));
        n_vec++;
        if (duty !== {8'd0, 8'd0, 8'd0, 8'd64}) begin n_bad++; $display("FAIL all_banks-old-duty: got %h expected 00000040", duty); end
        to_boundary();
        n_vec++;
        if (duty !== {8'd255, 8'd255, 8'd0, 8'd255}) begin n_bad++; $display("FAIL all_banks-duty: got %h expected ffff00ff", duty); end
        run_period();
        n_vec++;
        if (per_errs != 0) begin n_bad++; $display("FAIL all_banks-pattern: got %0d bad cycles expected 0", per_errs); end
        n_vec++;
        if (per_high[0] != 255 || per_high[1] != 0 || per_high[2] != 255 || per_high[3] != 255) begin
            n_bad++; $display("FAIL all_banks-high-ticks: got %0d/%0d/%0d/%0d expected 255/0/255/255",
                              per_high[0], per_high[1], per_high[2], per_high[3]);
        end
        n_vec++;
        if (bank_out !== 4'b1101) begin n_bad++; $display("FAIL all_banks-out: got %b expected 1101", bank_out); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words[6];
        logic [15:0] e;
        words = '{mk(BANK_OPCODE, 4'b0001, 8'd10), mk(BAD_OPC, 4'b0001, 8'd11),
                  mk(BANK_OPCODE, 4'b0010, 8'd20), mk(BAD_OPC, 4'b1111, 8'd21),
                  mk(BANK_OPCODE, 4'b0100, 8'd30), mk(BANK_OPCODE, 4'b1000, 8'd40)};
        valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            data = words[k];
            push_exp(words[k]);
            n_vec++;
            if (ready !== 1'b1) begin n_bad++; $display("FAIL b2b-ready-hi word%0d: got %b expected 1", k, ready); end
            step();
            n_vec++;
            if (ready !== 1'b0) begin n_bad++; $display("FAIL b2b-ready-lo word%0d: got %b expected 0", k, ready); end
            step();
            apply_shadow(words[k]);
            e = exp_bad_q.pop_front();
            n_vec++;
            if (bad !== e) begin n_bad++; $display("FAIL b2b-count word%0d: got %0d expected %0d", k, bad, e); end
        end
        valid = 1'b0;
        data  = '0;
        n_vec++;
        if (bad !== 16'd5) begin n_bad++; $display("FAIL b2b-total-count: got %0d expected 5", bad); end
        to_boundary();
        n_vec++;
        if (duty !== {8'd40, 8'd30, 8'd20, 8'd10}) begin n_bad++; $display("FAIL b2b-duty: got %h expected 281e140a", duty); end
    endtask

    task automatic test_period_edge();
        logic [15:0] e;
        for (int k = 0; k < 255 && (cyc % 255) != 253; k++) step();
        valid = 1'b1;
        data  = mk(BANK_OPCODE, 4'b0001, 8'd200);
        push_exp(data);
        step();
        valid = 1'b0;
        step();
        apply_shadow(mk(BANK_OPCODE, 4'b0001, 8'd200));
        e = exp_bad_q.pop_front();
        n_vec++;
        if (bad !== e) begin n_bad++; $display("FAIL edge-count: got %0d expected %0d", bad, e); end
        n_vec++;
        if (duty[0] !== 8'd10) begin n_bad++; $display("FAIL edge-old-duty: got %0d expected 10", duty[0]); end
        run_period();
        n_vec++;
        if (per_errs != 0 || per_high[0] != 10) begin
            n_bad++; $display("FAIL edge-old-period: got errs=%0d high=%0d expected 0/10", per_errs, per_high[0]);
        end
        n_vec++;
        if (duty[0] !== 8'd200) begin n_bad++; $display("FAIL edge-new-duty: got %0d expected 200", duty[0]); end
        run_period();
        n_vec++;
        if (per_errs != 0 || per_high[0] != 200) begin
            n_bad++; $display("FAIL edge-new-period: got errs=%0d high=%0d expected 0/200", per_errs, per_high[0]);
        end
    endtask

    task automatic test_saturate();
        force dut.bad_cmd_cnt_q = 16'hFFFF;
        #1;
        release dut.bad_cmd_cnt_q;
        exp_bad = 16'hFFFF;
        send_cmd("saturate", mk(BAD_OPC, 4'h0, 8'h00));
        n_vec++;
        if (bad !== 16'hFFFF) begin n_bad++; $display("FAIL saturate-hold: got %h expected ffff", bad); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 255 && (cyc % 255) != 3; k++) step();
        n_vec++;
        if (bank_out !== 4'hF) begin n_bad++; $display("FAIL rstmid-pre-out: got %b expected 1111", bank_out); end
        valid = 1'b1;
        data  = mk(BAD_OPC, 4'hF, 8'h12);
        step();
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ready, bank_out, duty, bad} !== '0) begin
            n_bad++; $display("FAIL rstmid-async: got rdy=%b out=%b duty=%h bad=%h expected all 0", ready, bank_out, duty, bad);
        end
        step(); step();
        do_release();
        n_vec++;
        if (ready !== 1'b0) begin n_bad++; $display("FAIL rstmid-release-ready: got %b expected 0", ready); end
        step();
        n_vec++;
        if (ready !== 1'b1) begin n_bad++; $display("FAIL rstmid-ready-after: got %b expected 1", ready); end
        step(); step(); step();
        n_vec++;
        if (bad !== 16'd0 || duty !== 32'h0 || bank_out !== 4'h0) begin
            n_bad++; $display("FAIL rstmid-discard: got bad=%h duty=%h out=%b expected 0/0/0", bad, duty, bank_out);
        end
    endtask

    initial begin
        test_reset();
        test_bad_opcode();
        test_duty64();
        test_all_banks();
        test_back_to_back();
        test_period_edge();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
